lab_test_sequencer: RTL and testbench

LAB_TEST_SEQUENCER -- requirements
Module: lab_test_sequencer

---
 rtl/lab_test_sequencer.sv | 225 ++++++++++++++++++++++
 tb/tb_lab_test_sequencer.sv | 348 ++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/lab_test_sequencer.sv
// lab_test_sequencer: walks one selected lab circuit (f, g or h) through every
// input vector, waits SETTLE cycles per vector, compares the observed output
// against the golden equation and reports the mismatch count and pass/fail.
// Optional feature: define SEQ_FAIL_LOG_EN to record the index of the first
// failing vector on first_fail/fail_valid (both tie to 0 otherwise).
module lab_test_sequencer #(
    parameter int unsigned SETTLE = 1
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       start,
    input  logic       abort,
    input  logic [1:0] sel,
    input  logic       f,
    input  logic       g,
    input  logic       h,
    output logic       a,
    output logic       b,
    output logic       c,
    output logic       d,
    output logic       busy,
    output logic       done,
    output logic       pass,
    output logic [4:0] err_count,
    output logic [3:0] vec_idx,
    output logic [3:0] first_fail,
    output logic       fail_valid
);

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_DRIVE,
        ST_SETTLE,
        ST_CHECK,
        ST_DONE
    } state_t;

    localparam logic [3:0] SETTLE_LAST = 4'(SETTLE - 1);

    state_t     r_state;
    state_t     w_next;
    logic [1:0] r_sel;
    logic [3:0] r_vec;          // registered stimulus {a,b,c,d}
    logic [3:0] r_vec_idx;
    logic [3:0] r_settle_cnt;
    logic [4:0] r_err_count;
    logic       r_done;
    logic       r_pass;

    logic [3:0] w_last_idx;
    logic [3:0] w_vec;
    logic       w_abort;
    logic       w_accept;
    logic       w_is_last;
    logic       w_settled;
    logic       w_va;
    logic       w_vb;
    logic       w_vc;
    logic       w_vd;
    logic       w_gold_f;
    logic       w_gold_g;
    logic       w_gold_h;
    logic       w_gold;
    logic       w_obs;
    logic       w_mismatch;

    assign w_abort   = abort && (r_state != ST_IDLE);
    assign w_accept  = (r_state == ST_IDLE) && start;
    assign w_is_last = (r_vec_idx == w_last_idx);
    assign w_settled = (r_settle_cnt == SETTLE_LAST);

    assign {w_va, w_vb, w_vc, w_vd} = r_vec;

    assign w_gold_f = w_va ^ w_vb;
    assign w_gold_g = (w_va & w_vc) | (w_vb & ~w_vc) | (w_va & w_vb);
    assign w_gold_h = ~((w_va & w_vb & w_vc) | ~(w_vc | w_vd)) | (w_vb & ~(w_vc | w_vd));

    // Per-circuit vector layout, last index and golden/observed selection
    always_comb begin
        w_last_idx = 4'd15;
        w_vec      = r_vec_idx;
        w_gold     = w_gold_h;
        w_obs      = h;
        case (r_sel)
            2'd0: begin
                w_last_idx = 4'd3;
                w_vec      = {r_vec_idx[1:0], 2'b00};
                w_gold     = w_gold_f;
                w_obs      = f;
            end
            2'd1: begin
                w_last_idx = 4'd7;
                w_vec      = {r_vec_idx[2:0], 1'b0};
                w_gold     = w_gold_g;
                w_obs      = g;
            end
            default: begin
                w_last_idx = 4'd15;
                w_vec      = r_vec_idx;
                w_gold     = w_gold_h;
                w_obs      = h;
            end
        endcase
        w_mismatch = (w_obs != w_gold);
    end

    // Next-state decode; abort outside IDLE overrides every other transition
    always_comb begin
        w_next = r_state;
        case (r_state)
            ST_IDLE: begin
                if (start) begin
                    w_next = (sel == 2'd3) ? ST_DONE : ST_DRIVE;
                end
            end
            ST_DRIVE:  w_next = ST_SETTLE;
            ST_SETTLE: begin
                if (w_settled) begin
                    w_next = ST_CHECK;
                end
            end
            ST_CHECK:  w_next = w_is_last ? ST_DONE : ST_DRIVE;
            ST_DONE:   w_next = ST_IDLE;
            default:   w_next = ST_IDLE;
        endcase
        if (w_abort) begin
            w_next = ST_IDLE;
        end
    end

    // State register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    // Run datapath: sel latch, stimulus, settle timer, vector index, scoring
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_sel        <= '0;
            r_vec        <= '0;
            r_vec_idx    <= '0;
            r_settle_cnt <= '0;
            r_err_count  <= '0;
            r_done       <= 1'b0;
            r_pass       <= 1'b0;
        end else begin
            r_done <= 1'b0;
            if (w_abort) begin
                r_vec <= '0;
            end else begin
                case (r_state)
                    ST_IDLE: begin
                        if (start) begin
                            r_sel       <= sel;
                            r_vec_idx   <= '0;
                            r_err_count <= '0;
                            r_pass      <= 1'b0;
                        end
                    end
                    ST_DRIVE: begin
                        r_vec        <= w_vec;
                        r_settle_cnt <= '0;
                    end
                    ST_SETTLE: begin
                        r_settle_cnt <= r_settle_cnt + 4'd1;
                    end
                    ST_CHECK: begin
                        if (w_mismatch) begin
                            r_err_count <= r_err_count + 5'd1;
                        end
                        if (!w_is_last) begin
                            r_vec_idx <= r_vec_idx + 4'd1;
                        end
                    end
                    ST_DONE: begin
                        // done and pass are registered on the DONE exit edge
                        r_done <= 1'b1;
                        r_pass <= (r_sel != 2'd3) && (r_err_count == 5'd0);
                        r_vec  <= '0;
                    end
                    default: begin
                        r_vec <= '0;
                    end
                endcase
            end
        end
    end

`ifdef SEQ_FAIL_LOG_EN
    logic [3:0] r_first_fail;
    logic       r_fail_valid;

    // Capture the index of the first mismatching vector of the run
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_first_fail <= '0;
            r_fail_valid <= 1'b0;
        end else if (w_accept) begin
            r_first_fail <= '0;
            r_fail_valid <= 1'b0;
        end else if (!w_abort && (r_state == ST_CHECK) && w_mismatch && !r_fail_valid) begin
            r_first_fail <= r_vec_idx;
            r_fail_valid <= 1'b1;
        end
    end

    assign first_fail = r_first_fail;
    assign fail_valid = r_fail_valid;
`else
    assign first_fail = '0;
    assign fail_valid = 1'b0;
`endif

    assign {a, b, c, d} = r_vec;
    assign busy         = (r_state == ST_DRIVE) || (r_state == ST_SETTLE) || (r_state == ST_CHECK);
    assign done         = r_done;
    assign pass         = r_pass;
    assign err_count    = r_err_count;
    assign vec_idx      = r_vec_idx;

endmodule

// File: tb/tb_lab_test_sequencer.sv
// Self-checking bench for lab_test_sequencer: behavioural lab circuits with
// injectable faults, a vector-level reference model and timed run checks.
module tb_lab_test_sequencer;

    localparam int TB_SETTLE = 1;
    localparam int VEC_CYC   = TB_SETTLE + 2;

    logic       clk = 1'b0;
    logic       rst;
    logic       start;
    logic       abort;
    logic [1:0] sel;
    logic       f;
    logic       g;
    logic       h;
    logic       a;
    logic       b;
    logic       c;
    logic       d;
    logic       busy;
    logic       done;
    logic       pass;
    logic [4:0] err_count;
    logic [3:0] vec_idx;
    logic [3:0] first_fail;
    logic       fail_valid;

    int checks = 0;
    int errors = 0;

    // Fault injection for the circuit under test: 0 good, 1 stuck-at-0,
    // 2 inverted, 3 flipped on the vectors marked in fmask.
    int          cur_sel = 0;
    int          fmode   = 0;
    logic [15:0] fmask   = '0;

    logic [3:0] t_vec;
    logic [3:0] t_idx;
    logic       t_gf;
    logic       t_gg;
    logic       t_gh;
    logic       t_gs;
    logic       t_bad;

    lab_test_sequencer #(.SETTLE(TB_SETTLE)) dut (
        .clk        (clk),
        .rst        (rst),
        .start      (start),
        .abort      (abort),
        .sel        (sel),
        .f          (f),
        .g          (g),
        .h          (h),
        .a          (a),
        .b          (b),
        .c          (c),
        .d          (d),
        .busy       (busy),
        .done       (done),
        .pass       (pass),
        .err_count  (err_count),
        .vec_idx    (vec_idx),
        .first_fail (first_fail),
        .fail_valid (fail_valid)
    );

    always #5 clk = ~clk;

    function automatic logic gold(input int s, input logic [3:0] v);
        logic va, vb, vc, vd;
        {va, vb, vc, vd} = v;
        if (s == 0) return va ^ vb;
        if (s == 1) return (va & vc) | (vb & ~vc) | (va & vb);
        return ~((va & vb & vc) | ~(vc | vd)) | (vb & ~(vc | vd));
    endfunction

    // Vector i placed MSB-first on a..d: shift left by the unused pins
    function automatic logic [3:0] vec_of(input int s, input int idx);
        return 4'(idx << (2 - s));
    endfunction

    function automatic int vec_count(input int s);
        if (s > 2) return 0;
        return 1 << (s + 2);
    endfunction

    // Lab circuits; only the one under test carries the fault
    always_comb begin
        t_vec = {a, b, c, d};
        t_idx = (cur_sel <= 2) ? 4'(t_vec >> (2 - cur_sel)) : t_vec;
        t_gf  = gold(0, t_vec);
        t_gg  = gold(1, t_vec);
        t_gh  = gold(2, t_vec);
        t_gs  = (cur_sel == 0) ? t_gf : (cur_sel == 1) ? t_gg : t_gh;
        case (fmode)
            0:       t_bad = t_gs;
            1:       t_bad = 1'b0;
            2:       t_bad = ~t_gs;
            default: t_bad = t_gs ^ fmask[t_idx];
        endcase
        f = (cur_sel == 0) ? t_bad : t_gf;
        g = (cur_sel == 1) ? t_bad : t_gg;
        h = (cur_sel == 2) ? t_bad : t_gh;
    end

    // One complete run from start to one cycle past done, checked every cycle
    task automatic run_and_check(input int s, input int mode, input logic [15:0] mask,
                                 input bit poke, input string name);
        int   n, expect_done, exp_err, exp_ff;
        bit   exp_fv, exp_pass, mis, exp_busy, exp_done;
        logic [3:0] v;
        cur_sel = s;
        fmode   = mode;
        fmask   = mask;
        n       = vec_count(s);
        exp_err = 0;
        exp_ff  = 0;
        exp_fv  = 1'b0;
        for (int i = 0; i < n; i++) begin
            v = vec_of(s, i);
            case (mode)
                0:       mis = 1'b0;
                1:       mis = gold(s, v);
                2:       mis = 1'b1;
                default: mis = mask[i];
            endcase
            if (mis) begin
                if (!exp_fv) begin
                    exp_ff = i;
                    exp_fv = 1'b1;
                end
                exp_err++;
            end
        end
`ifndef SEQ_FAIL_LOG_EN
        exp_ff = 0;
        exp_fv = 1'b0;
`endif
        exp_pass    = (s != 3) && (exp_err == 0);
        expect_done = 1 + n * VEC_CYC;

        sel   = s[1:0];
        start = 1'b1;
        @(posedge clk);
        #1;
        sel = 2'($urandom_range(0, 3));
        for (int k = 0; k <= expect_done + 1; k++) begin
            if (k > 0) begin
                @(posedge clk);
                #1;
            end
            start = 1'b0;
            if (k == 0) begin
                checks++;
                if (pass !== 1'b0 || err_count !== 5'd0 || vec_idx !== 4'd0) begin
                    errors++;
                    $display("FAIL %s start_clear: pass=%b err=%0d idx=%0d, need 0/0/0",
                             name, pass, err_count, vec_idx);
                end
            end
            exp_busy = (k < n * VEC_CYC);
            checks++;
            if (busy !== exp_busy) begin
                errors++;
                $display("FAIL %s busy k=%0d: got %b need %b", name, k, busy, exp_busy);
            end
            exp_done = (k == expect_done);
            checks++;
            if (done !== exp_done) begin
                errors++;
                $display("FAIL %s done k=%0d: got %b need %b", name, k, done, exp_done);
            end
            if ((k % VEC_CYC) == 1 && (k / VEC_CYC) < n) begin
                checks++;
                if ({a, b, c, d} !== vec_of(s, k / VEC_CYC) || vec_idx !== 4'(k / VEC_CYC)) begin
                    errors++;
                    $display("FAIL %s vector k=%0d: abcd=%b idx=%0d, need abcd=%b idx=%0d",
                             name, k, {a, b, c, d}, vec_idx, vec_of(s, k / VEC_CYC), k / VEC_CYC);
                end
            end
            if (k == expect_done) begin
                checks++;
                if (err_count !== 5'(exp_err) || pass !== exp_pass) begin
                    errors++;
                    $display("FAIL %s result: err=%0d pass=%b, need err=%0d pass=%b",
                             name, err_count, pass, exp_err, exp_pass);
                end
                checks++;
                if (first_fail !== 4'(exp_ff) || fail_valid !== exp_fv) begin
                    errors++;
                    $display("FAIL %s fail_log: first_fail=%0d valid=%b, need %0d/%b",
                             name, first_fail, fail_valid, exp_ff, exp_fv);
                end
                checks++;
                if ({a, b, c, d} !== 4'b0000) begin
                    errors++;
                    $display("FAIL %s idle_stim: abcd=%b need 0000", name, {a, b, c, d});
                end
            end
            if (poke && (k == 2 || k == n * VEC_CYC - 1 || k == n * VEC_CYC)) begin
                start = 1'b1;
            end
        end
        start = 1'b0;
    endtask

    task automatic test_reset();
        rst   = 1'b1;
        start = 1'b0;
        abort = 1'b0;
        sel   = 2'd0;
        repeat (3) @(posedge clk);
        #1;
        checks++;
        if ({a, b, c, d, busy, done, pass, err_count, vec_idx, first_fail, fail_valid} !== '0) begin
            errors++;
            $display("FAIL reset_state: abcd=%b busy=%b done=%b pass=%b err=%0d idx=%0d ff=%0d fv=%b, need all 0",
                     {a, b, c, d}, busy, done, pass, err_count, vec_idx, first_fail, fail_valid);
        end
        rst = 1'b0;
        @(posedge clk);
        #1;
    endtask

    task automatic test_sel0_pass();
        run_and_check(0, 0, '0, 1'b0, "sel0_good");
    endtask

    task automatic test_sel2_stuck0();
        run_and_check(2, 1, '0, 1'b0, "sel2_h_stuck0");
    endtask

    task automatic test_sel1_inverted();
        run_and_check(1, 2, '0, 1'b0, "sel1_g_inverted");
    endtask

    task automatic test_invalid_and_busy();
        run_and_check(3, 0, '0, 1'b1, "sel3_invalid");
        for (int s = 0; s < 3; s++) begin
            run_and_check(s, 3, 16'($urandom), 1'b1, "start_while_busy");
        end
    endtask

    task automatic test_abort();
        bit seen;
        cur_sel = 2;
        fmode   = 3;
        fmask   = 16'($urandom);
        sel     = 2'd2;
        start   = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        for (int k = 1; k <= 5 * VEC_CYC + 1; k++) begin
            @(posedge clk);
            #1;
        end
        checks++;
        if (vec_idx !== 4'd5 || busy !== 1'b1) begin
            errors++;
            $display("FAIL abort_setup: idx=%0d busy=%b, need 5/1", vec_idx, busy);
        end
        abort = 1'b1;
        @(posedge clk);
        #1;
        abort = 1'b0;
        checks++;
        if (busy !== 1'b0 || done !== 1'b0 || {a, b, c, d} !== 4'b0000) begin
            errors++;
            $display("FAIL abort_idle: busy=%b done=%b abcd=%b, need 0/0/0000", busy, done, {a, b, c, d});
        end
        seen = 1'b0;
        for (int k = 0; k < 60; k++) begin
            @(posedge clk);
            #1;
            if (done === 1'b1 || busy === 1'b1) seen = 1'b1;
        end
        checks++;
        if (seen) begin
            errors++;
            $display("FAIL abort_quiet: done/busy seen=%b after abort, need 0", seen);
        end
        run_and_check(2, 0, '0, 1'b0, "after_abort");
    endtask

    task automatic test_reset_midrun();
        int  s, stop;
        bit  seen;
        s       = $urandom_range(0, 2);
        stop    = $urandom_range(2, vec_count(s) * VEC_CYC - 2);
        cur_sel = s;
        fmode   = 2;
        sel     = s[1:0];
        start   = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        for (int k = 1; k <= stop; k++) begin
            @(posedge clk);
            #1;
        end
        #2;
        rst = 1'b1;
        #1;
        checks++;
        if ({a, b, c, d, busy, done, pass, err_count, vec_idx, first_fail, fail_valid} !== '0) begin
            errors++;
            $display("FAIL reset_midrun: abcd=%b busy=%b done=%b pass=%b err=%0d idx=%0d ff=%0d fv=%b, need all 0",
                     {a, b, c, d}, busy, done, pass, err_count, vec_idx, first_fail, fail_valid);
        end
        @(posedge clk);
        #1;
        rst  = 1'b0;
        seen = 1'b0;
        for (int k = 0; k < 60; k++) begin
            @(posedge clk);
            #1;
            if (done === 1'b1 || busy === 1'b1) seen = 1'b1;
        end
        checks++;
        if (seen) begin
            errors++;
            $display("FAIL reset_quiet: done/busy seen=%b after reset, need 0", seen);
        end
        run_and_check(s, 0, '0, 1'b0, "after_reset");
    endtask

    task automatic test_random();
        for (int r = 0; r < 10; r++) begin
            run_and_check($urandom_range(0, 3), $urandom_range(0, 3), 16'($urandom),
                          1'($urandom_range(0, 1)), "random");
        end
    endtask

    initial begin
        test_reset();
        test_sel0_pass();
        test_sel2_stuck0();
        test_sel1_inverted();
        test_invalid_and_busy();
        test_abort();
        test_reset_midrun();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
